// File: rtl/mac_sequencer.sv
// Dot-product sequencer: two operand buffers streamed into an external MAC.
// Ports: buffer write (wr_*), start/len, MAC drive (mac_*), result handshake (res_*).
module mac_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       err,
  output logic                       mac_clr,
  output logic                       mac_en,
  output logic [DATA_W-1:0]          mac_a,
  output logic [DATA_W-1:0]          mac_b,
  input  logic [ACC_W-1:0]           mac_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [LW-1:0]   len_q;
  logic [DW-1:0]   dcnt;

  logic [DATA_W-1:0] buf_a [DEPTH];
  logic [DATA_W-1:0] buf_b [DEPTH];

  logic          wr_ok;
  logic          len_ok;
  logic          last;
  logic          drain_done;
  logic [AW-1:0] nxt;

  assign wr_ok = wr_en
               && (state == S_IDLE || state == S_HOLD)
               && ({1'b0, wr_addr} < LW'(DEPTH));
  assign len_ok = (len != '0) && (len <= LW'(DEPTH));
  // idx is the entry currently on mac_a/mac_b
  assign last = ({1'b0, idx} == len_q - LW'(1));
  assign nxt = idx + AW'(1);
  assign drain_done = (dcnt == DW'(MAC_LAT - 1));

  // Operand storage survives reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) buf_b[wr_addr] <= wr_data;
      else        buf_a[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      len_q     <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q   <= len;
              busy    <= 1'b1;
              mac_clr <= 1'b1;
              state   <= S_CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          mac_clr <= 1'b0;
          mac_en  <= 1'b1;
          mac_a   <= buf_a[0];
          mac_b   <= buf_b[0];
          idx     <= '0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (last) begin
            mac_en <= 1'b0;
            mac_a  <= '0;
            mac_b  <= '0;
            dcnt   <= '0;
            state  <= S_DRAIN;
          end else begin
            idx   <= nxt;
            mac_a <= buf_a[nxt];
            mac_b <= buf_b[nxt];
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            res_data  <= mac_out;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_HOLD;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural MAC and a dot-product model.
// Ports: drives all DUT inputs, models the MAC on mac_* and checks res_*.
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic start = 1'b0;
  logic [4:0] len = '0;
  logic res_ready = 1'b0;
  logic busy, err, mac_clr, mac_en, res_valid;
  logic signed [15:0] mac_a, mac_b;
  logic signed [39:0] mac_out = '0;
  logic signed [39:0] res_data;
  logic signed [31:0] prod;

  logic signed [15:0] ma [16];
  logic signed [15:0] mb [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len),
    .busy(busy), .err(err),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  // Behavioural MAC, one cycle latency
  assign prod = mac_a * mac_b;
  always @(posedge clk) begin
    if (mac_clr) mac_out <= '0;
    else if (mac_en) mac_out <= mac_out + {{8{prod[31]}}, prod};
  end

  function automatic logic signed [39:0] dot(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++)
      s += longint'(ma[i]) * longint'(mb[i]);
    return s[39:0];
  endfunction

  // Write performed while the DUT is IDLE or HOLD, mirrored in the model
  task automatic wr(input bit sel, input int addr, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[addr] = d;
    else     ma[addr] = d;
  endtask

  task automatic run_dot(input int n, input bit inj, input string nm);
    logic signed [39:0] exp;
    int clr_n, en_n, bad, rv_c, busy_bad;
    exp = dot(n);
    clr_n = 0; en_n = 0; bad = 0; rv_c = -1; busy_bad = 0;
    @(negedge clk);
    start = 1'b1; len = 5'(n);
    for (int c = 0; c < n + 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inj && c == 2) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd2; wr_data = 16'd100;
      end else begin
        wr_en = 1'b0;
      end
      if (mac_clr) begin
        clr_n++;
        if (c != 0) bad++;
      end
      if (mac_en) begin
        if (en_n > 15 || c != en_n + 1 ||
            mac_a !== ma[en_n] || mac_b !== mb[en_n]) bad++;
        en_n++;
      end else if (mac_a !== '0 || mac_b !== '0) begin
        bad++;
      end
      if (busy !== (c <= n + 1)) busy_bad++;
      if (res_valid) begin
        rv_c = c;
        break;
      end
    end
    wr_en = 1'b0;
    tests++;
    if (clr_n != 1) begin
      fails++;
      $display("FAIL %s clr_cycles got %0d want 1", nm, clr_n);
    end
    tests++;
    if (en_n != n) begin
      fails++;
      $display("FAIL %s en_cycles got %0d want %0d", nm, en_n, n);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s operand_seq bad=%0d want 0", nm, bad);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL %s busy bad=%0d want 0", nm, busy_bad);
    end
    tests++;
    if (rv_c != n + 2) begin
      fails++;
      $display("FAIL %s res_valid_cycle got %0d want %0d", nm, rv_c, n + 2);
    end
    tests++;
    if (res_data !== exp) begin
      fails++;
      $display("FAIL %s res_data got %0d want %0d", nm, res_data, exp);
    end
  endtask

  task automatic ack(input string nm);
    logic signed [39:0] held;
    held = res_data;
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== held) begin
      fails++;
      $display("FAIL %s ack got v=%b b=%b d=%0d want v=0 b=0 d=%0d",
               nm, res_valid, busy, res_data, held);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({busy, err, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data}
        !== '0) begin
      fails++;
      $display("FAIL reset outputs got nonzero want 0");
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 16'(i + 1));
      wr(1'b1, i, 16'(i + 5));
    end
    run_dot(4, 1'b0, "basic");
    tests++;
    if (res_data !== 40'sd70) begin
      fails++;
      $display("FAIL basic_70 got %0d want 70", res_data);
    end
    ack("basic");
  endtask

  task automatic test_hold();
    logic signed [39:0] exp;
    int bad;
    bad = 0;
    run_dot(4, 1'b0, "hold_run");
    exp = dot(4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp ||
          busy !== 1'b0 || mac_clr !== 1'b0) bad++;
      start = k[0]; len = 5'd4;
      wr_en = (k < 4); wr_sel = 1'b1; wr_addr = 4'(k);
      wr_data = 16'(k * 3 - 7);
      if (k < 4) mb[k] = 16'(k * 3 - 7);
    end
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_stable bad=%0d want 0", bad);
    end
    // handshake with a coincident start: start must be dropped
    res_ready = 1'b1; start = 1'b1; len = 5'd4;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== exp) begin
      fails++;
      $display("FAIL hold_ack got v=%b b=%b d=%0d want v=0 b=0 d=%0d",
               res_valid, busy, res_data, exp);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mac_clr !== 1'b0) begin
      fails++;
      $display("FAIL hold_start_ignored got b=%b clr=%b want 0 0",
               busy, mac_clr);
    end
    run_dot(4, 1'b0, "hold_writes");
    ack("hold_writes");
  endtask

  task automatic test_err();
    int lens [2];
    lens[0] = 0; lens[1] = 17;
    foreach (lens[j]) begin
      @(negedge clk); start = 1'b1; len = 5'(lens[j]);
      @(negedge clk); start = 1'b0;
      tests++;
      if (err !== 1'b1 || busy !== 1'b0 || mac_clr !== 1'b0) begin
        fails++;
        $display("FAIL err_len%0d got e=%b b=%b c=%b want 1 0 0",
                 lens[j], err, busy, mac_clr);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0 || busy !== 1'b0 || mac_clr !== 1'b0) begin
        fails++;
        $display("FAIL err_pulse_len%0d got e=%b b=%b c=%b want 0 0 0",
                 lens[j], err, busy, mac_clr);
      end
    end
  endtask

  task automatic test_ignored_write();
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, i, 16'(i + 1));
      wr(1'b1, i, 16'(i + 5));
    end
    run_dot(4, 1'b1, "stream_write");
    tests++;
    if (res_data !== 40'sd70) begin
      fails++;
      $display("FAIL stream_write_70 got %0d want 70", res_data);
    end
    ack("stream_write");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk); start = 1'b1; len = 5'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, err, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data}
        !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs got nonzero want 0");
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0 || mac_en !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_mid_abort bad=%0d want 0", bad);
    end
    run_dot(4, 1'b0, "reset_rerun");
    tests++;
    if (res_data !== 40'sd70) begin
      fails++;
      $display("FAIL reset_rerun_70 got %0d want 70", res_data);
    end
    ack("reset_rerun");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 16'h8000);
      wr(1'b1, i, 16'h8000);
    end
    run_dot(16, 1'b0, "full");
    tests++;
    if (res_data !== 40'sd17179869184) begin
      fails++;
      $display("FAIL full_value got %0d want 17179869184", res_data);
    end
    ack("full");
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++)
        wr(1'($urandom), int'($urandom_range(15, 0)), 16'($urandom));
      n = int'($urandom_range(16, 1));
      run_dot(n, 1'b0, $sformatf("rand%0d_len%0d", r, n));
      ack("rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    test_reset();
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 16'd0);
      wr(1'b1, i, 16'd0);
    end
    test_basic();
    test_hold();
    test_err();
    test_ignored_write();
    test_reset_mid();
    test_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DATA_W, 16, signed two's-complement operand width.
REQ-002 Parameter ACC_W, 40, accumulator/result width.
REQ-003 Parameter DEPTH, 16, entries per operand buffer.
REQ-004 Parameter MAC_LAT, 1, cycles from last operand presented to valid MAC output.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  operand buffer write strobe.
REQ-008 wr_sel  in  1  buffer select: 0 = A, 1 = B.
REQ-009 wr_addr  in  $clog2(DEPTH)  write address.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 start  in  1  single-cycle request to run one dot product.
REQ-012 len  in  $clog2(DEPTH)+1  vector length, sampled with start.
REQ-013 busy  out  1  high in CLEAR, STREAM, DRAIN.
REQ-014 err  out  1  one-cycle pulse on rejected start.
REQ-015 mac_clr  out  1  accumulator clear to downstream MAC.
REQ-016 mac_en  out  1  operand-valid to downstream MAC.
REQ-017 mac_a, mac_b  out  DATA_W each  operands to MAC.
REQ-018 mac_out  in  ACC_W  accumulated result from MAC.
REQ-019 res_valid  out  1  result available.
REQ-020 res_ready  in  1  consumer accepts result.
REQ-021 res_data  out  ACC_W  captured dot product.

Function
REQ-022 The block SHALL implement states IDLE, CLEAR, STREAM, DRAIN, HOLD; mac_clr, mac_en, mac_a, mac_b, busy, err, res_valid, res_data SHALL all be registered.
REQ-023 Writes SHALL be accepted only in IDLE and HOLD; wr_en in CLEAR/STREAM/DRAIN SHALL be ignored.
REQ-024 In IDLE, start with 1 <= len <= DEPTH SHALL latch len and go to CLEAR; start with len==0 or len>DEPTH SHALL pulse err for one cycle and stay IDLE.
REQ-025 start outside IDLE SHALL be ignored without err.
REQ-026 CLEAR SHALL last one cycle with mac_clr=1, mac_en=0, mac_a=mac_b=0, then enter STREAM with index 0.
REQ-027 STREAM SHALL present A[i], B[i] with mac_en=1 for exactly len consecutive cycles, i = 0..len-1 ascending, then enter DRAIN.
REQ-028 Outside STREAM, mac_en SHALL be 0 and mac_a=mac_b=0; mac_clr SHALL be 1 only in CLEAR.
REQ-029 DRAIN SHALL wait MAC_LAT cycles, then capture mac_out into res_data, set res_valid=1, enter HOLD.
REQ-030 Timing: start sampled at edge T0 -> mac_clr during cycle T0+1, operands during T0+2..T0+1+len, res_valid first high in cycle T0+2+len+MAC_LAT.
REQ-031 In HOLD, res_valid and res_data SHALL stay stable until res_valid&&res_ready at an edge; then res_valid=0 and state=IDLE on that edge.
REQ-032 A start coincident with the HOLD handshake SHALL be ignored; next start is accepted from IDLE.
REQ-033 res_data SHALL retain its last value after handshake until the next capture.
REQ-034 The index counter SHALL never address beyond len-1; len=DEPTH SHALL not wrap or overrun.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE and busy, err, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data to 0, regardless of state.
REQ-036 Operand buffer contents SHALL NOT be reset.
REQ-037 Reset mid-operation SHALL abort the run with no res_valid; a start after rst_n deasserts SHALL run normally.

Verification
REQ-038 len=4, A={1,2,3,4}, B={5,6,7,8}, behavioural MAC MAC_LAT=1 -> one mac_clr cycle, 4 ordered mac_en cycles, res_data=70, res_valid at T0+7.
REQ-039 res_ready low 10 cycles after res_valid -> res_data stable, start pulses ignored, buffer writes accepted; res_ready high -> IDLE next cycle.
REQ-040 start with len=0, then len=17 -> err one cycle each, busy stays 0, no mac_clr.
REQ-041 wr_en to A[2] with 100 during STREAM of REQ-038 -> ignored, res_data=70.
REQ-042 rst_n low during STREAM cycle 2 -> all outputs 0 asynchronously, no res_valid; rerun REQ-038 -> 70.
REQ-043 len=16, all A=B=-32768 -> res_data=16*2^30=17179869184, no overrun past entry 15.
